// File: rtl/fpa_issue_arbiter_if.sv
// Requester, adder and sequencer signals of the shared FP-adder issue arbiter.
// The slave modport is the arbiter side; master is the surrounding system.
interface fpa_issue_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);
    logic             req0_valid_in;
    logic [WIDTH-1:0] req0_a_in;
    logic [WIDTH-1:0] req0_b_in;
    logic             req0_ready_out;
    logic             req1_valid_in;
    logic [WIDTH-1:0] req1_a_in;
    logic [WIDTH-1:0] req1_b_in;
    logic             req1_ready_out;
    logic [WIDTH-1:0] add_a_out;
    logic [WIDTH-1:0] add_b_out;
    logic             add_start_out;
    logic [WIDTH-1:0] add_result_in;
    logic             res0_valid_out;
    logic             res1_valid_out;
    logic [WIDTH-1:0] res_data_out;
    logic             drain_in;
    logic [CNT_W-1:0] inflight_out;
    logic             idle_out;

    modport slave (
        input  req0_valid_in, req0_a_in, req0_b_in,
        input  req1_valid_in, req1_a_in, req1_b_in,
        input  add_result_in, drain_in,
        output req0_ready_out, req1_ready_out,
        output add_a_out, add_b_out, add_start_out,
        output res0_valid_out, res1_valid_out, res_data_out,
        output inflight_out, idle_out
    );

    modport master (
        output req0_valid_in, req0_a_in, req0_b_in,
        output req1_valid_in, req1_a_in, req1_b_in,
        output add_result_in, drain_in,
        input  req0_ready_out, req1_ready_out,
        input  add_a_out, add_b_out, add_start_out,
        input  res0_valid_out, res1_valid_out, res_data_out,
        input  inflight_out, idle_out
    );
endinterface

// File: rtl/fpa_issue_arbiter.sv
// Round-robin issue of two requesters into one pipelined FP adder; start one cycle after handshake, result pulse LATENCY+1 after it.
// Ready is withheld (same cycle) on drain or when MAX_INFLIGHT operations are outstanding; results are never back-pressured.
module fpa_issue_arbiter #(
    parameter int WIDTH        = 32,
    parameter int LATENCY      = 17,
    parameter int MAX_INFLIGHT = 18,
    parameter int CNT_W        = $clog2(LATENCY + 2)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fpa_issue_arbiter_if.slave bus
);
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_start_q, add_start_d;
    tag_t             tag_q [LATENCY];
    tag_t             tag_d [LATENCY];
    logic             res0_vld_q, res0_vld_d;
    logic             res1_vld_q, res1_vld_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic can_issue;
    logic grant0, grant1;
    logic hs0, hs1, hs;
    logic retire;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        can_issue = !bus.drain_in && (inflight_q < CNT_W'(MAX_INFLIGHT));
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (can_issue) begin
            if (bus.req0_valid_in && bus.req1_valid_in) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid_in;
                grant1 = bus.req1_valid_in;
            end
        end
    end

    assign hs0    = bus.req0_valid_in && grant0;
    assign hs1    = bus.req1_valid_in && grant1;
    assign hs     = hs0 || hs1;
    assign retire = res0_vld_q || res1_vld_q;

    always_comb begin
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_start_d  = hs;
        last_grant_d = last_grant_q;
        if (hs0) begin
            add_a_d      = bus.req0_a_in;
            add_b_d      = bus.req0_b_in;
            last_grant_d = 1'b0;
        end else if (hs1) begin
            add_a_d      = bus.req1_a_in;
            add_b_d      = bus.req1_b_in;
            last_grant_d = 1'b1;
        end
    end

    // Tags shift every cycle in lock-step with the adder pipeline.
    always_comb begin
        tag_d[0] = '{vld: hs, id: hs1};
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign res0_vld_d = tag_q[LATENCY-1].vld && !tag_q[LATENCY-1].id;
    assign res1_vld_d = tag_q[LATENCY-1].vld &&  tag_q[LATENCY-1].id;

    // Simultaneous issue and retire leave the count unchanged.
    always_comb begin
        inflight_d = inflight_q;
        if (hs && !retire) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!hs && retire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant_q <= 1'b1;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_start_q  <= 1'b0;
            res0_vld_q   <= 1'b0;
            res1_vld_q   <= 1'b0;
            inflight_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_start_q  <= add_start_d;
            res0_vld_q   <= res0_vld_d;
            res1_vld_q   <= res1_vld_d;
            inflight_q   <= inflight_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.req0_ready_out = grant0;
    assign bus.req1_ready_out = grant1;
    assign bus.add_a_out      = add_a_q;
    assign bus.add_b_out      = add_b_q;
    assign bus.add_start_out  = add_start_q;
    assign bus.res0_valid_out = res0_vld_q;
    assign bus.res1_valid_out = res1_vld_q;
    assign bus.res_data_out   = bus.add_result_in;
    assign bus.inflight_out   = inflight_q;
    assign bus.idle_out       = (inflight_q == '0) && !add_start_q;
endmodule

// File: tb/tb_fpa_issue_arbiter.sv
// Bench for fpa_issue_arbiter: default instance plus a MAX_INFLIGHT=4 instance, each with a stand-in adder pipeline.
// Issued handshakes push expected results; per-instance monitors pop and compare on every result pulse.
module tb_fpa_issue_arbiter;
    localparam int W   = 32;
    localparam int LAT = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0, drn = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int          inst;
        int          id;
        logic [31:0] dat;
        int          due;
    } exp_t;
    exp_t sbq[$];

    logic [1:0]       r0_v, r1_v, st_v, idl_v;
    logic [1:0][31:0] aa_v, ab_v;
    logic [1:0][4:0]  inf_v;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return x + {y[30:0], 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        fpa_issue_arbiter_if #(.WIDTH(W), .CNT_W(5)) bus ();
        fpa_issue_arbiter #(.WIDTH(W), .LATENCY(LAT), .MAX_INFLIGHT(g == 0 ? 18 : 4), .CNT_W(5)) dut (
            .clk_in(clk),
            .rst_in(rst),
            .bus   (bus)
        );
        logic [W-1:0] pipe [LAT];

        assign bus.req0_valid_in = v0 && (sel == 1'(g));
        assign bus.req1_valid_in = v1 && (sel == 1'(g));
        assign bus.drain_in      = drn && (sel == 1'(g));
        assign bus.req0_a_in     = a0;
        assign bus.req0_b_in     = b0;
        assign bus.req1_a_in     = a1;
        assign bus.req1_b_in     = b1;
        assign bus.add_result_in = pipe[LAT-1];
        assign r0_v[g]  = bus.req0_ready_out;
        assign r1_v[g]  = bus.req1_ready_out;
        assign st_v[g]  = bus.add_start_out;
        assign idl_v[g] = bus.idle_out;
        assign aa_v[g]  = bus.add_a_out;
        assign ab_v[g]  = bus.add_b_out;
        assign inf_v[g] = bus.inflight_out;

        always @(posedge clk) begin
            pipe[0] <= fadd(bus.add_a_out, bus.add_b_out);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        always @(negedge clk) begin : mon
            int   n;
            exp_t e;
            if (!rst) begin
                n = 0;
                foreach (sbq[i]) if (sbq[i].inst == g) n++;
                chk($sformatf("inflight%0d", g), 32'(bus.inflight_out), n);
                if (bus.res0_valid_out || bus.res1_valid_out) begin
                    chk("res_onehot", 32'(bus.res0_valid_out & bus.res1_valid_out), 0);
                    if (sbq.size() == 0 || sbq[0].inst != g) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected inst %0d at cycle %0d: actual pulse, expected none", g, cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("res_id", 32'(bus.res1_valid_out), e.id);
                        chk("res_data", bus.res_data_out, e.dat);
                        chk("res_cycle", cyc, e.due);
                    end
                end else if (sbq.size() != 0 && sbq[0].inst == g && sbq[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL res_missing inst %0d at cycle %0d: actual none, expected pulse at %0d",
                             g, cyc, sbq[0].due);
                    e = sbq.pop_front();
                end
            end
        end
    end

    // One cycle: inputs already set; check readies, record expected results.
    task automatic tick(input logic e0, input logic e1);
        int          hc;
        logic [31:0] ca0, cb0, ca1, cb1;
        @(negedge clk);
        chk("ready0", 32'(r0_v[sel]), 32'(e0));
        chk("ready1", 32'(r1_v[sel]), 32'(e1));
        hc = cyc; ca0 = a0; cb0 = b0; ca1 = a1; cb1 = b1;
        @(posedge clk);
        if (e0) sbq.push_back('{inst: int'(sel), id: 0, dat: fadd(ca0, cb0), due: hc + LAT + 1});
        if (e1) sbq.push_back('{inst: int'(sel), id: 1, dat: fadd(ca1, cb1), due: hc + LAT + 1});
        #1;
    endtask

    task automatic idle_tick();
        v0 = 1'b0; v1 = 1'b0; drn = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; drn = 1'b0;
        repeat (n) @(posedge clk);
        sbq.delete();
        #1 rst = 1'b0;
    endtask

    task automatic drain_wait(input string nm);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 60) begin
            idle_tick();
            k++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual %0d results pending, expected 0", nm, sbq.size());
            sbq.delete();
        end
        @(negedge clk);
        chk({nm, "_idle"}, 32'(idl_v[sel]), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        // Reset state and single issue on instance 0.
        sel = 1'b0;
        do_reset(3);
        @(negedge clk);
        chk("rst_start", 32'(st_v[0]), 0);
        chk("rst_add_a", aa_v[0], 0);
        chk("rst_add_b", ab_v[0], 0);
        chk("rst_idle", 32'(idl_v[0]), 1);
        chk("rst_inflight", 32'(inf_v[0]), 0);
        @(posedge clk); #1;
        repeat (4) idle_tick();
        v0 = 1'b1; a0 = 32'h3F80_0000; b0 = 32'h4000_0000;
        tick(1'b1, 1'b0);
        v0 = 1'b0;
        @(negedge clk);
        chk("issue_start", 32'(st_v[0]), 1);
        chk("issue_a", aa_v[0], 32'h3F80_0000);
        chk("issue_b", ab_v[0], 32'h4000_0000);
        chk("issue_idle", 32'(idl_v[0]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("start_pulse_end", 32'(st_v[0]), 0);
        chk("hold_a", aa_v[0], 32'h3F80_0000);
        @(posedge clk); #1;
        drain_wait("single");

        // Contention from reset: req0 first, then alternate.
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            v0 = 1'b1; a0 = 32'h1000_0000 + 32'(k); b0 = 32'h0000_0100 + 32'(k);
            v1 = 1'b1; a1 = 32'h2000_0000 + 32'(k); b1 = 32'h0000_0200 + 32'(k);
            tick(k % 2 == 0, k % 2 == 1);
        end
        drain_wait("contention");

        // Drain: three issues, then drain with req0 still requesting.
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1; a0 = 32'h3000_0000 + 32'(k); b0 = 32'(k * 5);
            tick(1'b1, 1'b0);
        end
        drn = 1'b1;
        for (int k = 3; k < 20; k++) tick(1'b0, 1'b0);
        @(negedge clk);
        chk("drain_ready", 32'(r0_v[0]), 0);
        chk("drain_busy", 32'(idl_v[0]), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_idle", 32'(idl_v[0]), 1);
        chk("drain_ready_idle", 32'(r0_v[0]), 0);
        @(posedge clk); #1;
        drn = 1'b0; a0 = 32'h3100_0000;
        tick(1'b1, 1'b0);
        drain_wait("drain");

        // Reset mid-flight, then the next contention must go to req0.
        do_reset(2);
        repeat (5) idle_tick();
        for (int k = 0; k < 5; k++) begin
            v0 = 1'b1; a0 = 32'h5000_0000 + 32'(k); b0 = 32'(k);
            v1 = 1'b1; a1 = 32'h6000_0000 + 32'(k); b1 = 32'(k);
            tick(k % 2 == 0, k % 2 == 1);
        end
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk);
        sbq.delete();
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle", 32'(idl_v[0]), 1);
        chk("midrst_inflight", 32'(inf_v[0]), 0);
        @(posedge clk); #1;
        repeat (25) idle_tick();
        v0 = 1'b1; a0 = 32'h7000_0000; b0 = 32'h1;
        v1 = 1'b1; a1 = 32'h7100_0000; b1 = 32'h2;
        tick(1'b1, 1'b0);
        v0 = 1'b0;
        tick(1'b0, 1'b1);
        drain_wait("midrst");

        // Throttle on the MAX_INFLIGHT=4 instance with req1 always valid.
        sel = 1'b1;
        do_reset(2);
        for (int k = 0; k < 24; k++) begin
            v1 = 1'b1; a1 = 32'h4000_0000 + 32'(k); b1 = 32'(k * 7);
            tick(1'b0, (k < 4) || (k >= 19 && k <= 22));
        end
        drain_wait("throttle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
